// File: rtl/vga_pkg.sv
// Shared character-cell geometry, colour types and the 16-entry CGA palette
// used by the text renderer.
package vga_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
    } attr_t;

    localparam rgb12_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_blink_timer.sv
// Cursor blink timer: counts vsync_in rising edges and toggles blink_on
// every BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pxclk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic blink_on
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic          vsync_reg;
    logic [CW-1:0] frame_cnt_reg;
    logic          blink_on_reg;
    logic          vsync_rise;

    assign vsync_rise = vsync_in & ~vsync_reg;
    assign blink_on   = blink_on_reg;

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            vsync_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else begin
            vsync_reg <= vsync_in;
            if (vsync_rise) begin
                if (frame_cnt_reg == LAST) begin
                    frame_cnt_reg <= '0;
                    blink_on_reg  <= ~blink_on_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel pipeline: cell fetch from text RAM, glyph fetch from font ROM,
// cursor overlay and palette lookup, with syncs delayed to the same 3 cycles.
module vga_text_render
    import vga_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 640,
    parameter int PIXEL_HEIGHT = 480,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30,
    localparam int XW  = $clog2(PIXEL_WIDTH),
    localparam int YW  = $clog2(PIXEL_HEIGHT),
    localparam int TAW = $clog2(COLS * ROWS)
) (
    input  logic           pxclk,
    input  logic           rst_n,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic [XW-1:0]  xaddr,
    input  logic [YW-1:0]  yaddr,
    input  logic           addr_valid,
    output logic [TAW-1:0] text_addr,
    input  logic [15:0]    text_data,
    output logic [11:0]    font_addr,
    input  logic [7:0]     font_data,
    input  logic           cursor_en,
    input  logic [6:0]     cursor_col,
    input  logic [4:0]     cursor_row,
    output logic [3:0]     vga_r,
    output logic [3:0]     vga_g,
    output logic [3:0]     vga_b,
    output logic           hsync,
    output logic           vsync
);

    localparam int FCW = $clog2(CHAR_W);
    localparam int FRW = $clog2(CHAR_H);
    localparam int CCW = XW - FCW;
    localparam int CRW = YW - FRW;
    localparam logic [TAW-1:0] COLS_A = TAW'(COLS);

    logic blink_on;

    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .pxclk    (pxclk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .blink_on (blink_on)
    );

    // C0: cell address
    logic [CCW-1:0] cell_col;
    logic [CRW-1:0] cell_row;

    assign cell_col  = xaddr[XW-1:FCW];
    assign cell_row  = yaddr[YW-1:FRW];
    assign text_addr = TAW'(cell_row) * COLS_A + TAW'(cell_col);

    logic [FCW-1:0] fcol_s1_reg;
    logic [FRW-1:0] frow_s1_reg;
    logic [CCW-1:0] col_s1_reg;
    logic [CRW-1:0] row_s1_reg;
    logic           valid_s1_reg, hsync_s1_reg, vsync_s1_reg;
    logic           cur_en_s1_reg;
    logic [6:0]     cur_col_s1_reg;
    logic [4:0]     cur_row_s1_reg;

    // C1: glyph address and cursor hit
    attr_t attr;
    logic  cursor_hit;

    assign attr       = attr_t'(text_data[15:8]);
    assign font_addr  = {text_data[7:0], frow_s1_reg};
    assign cursor_hit = cur_en_s1_reg & blink_on
                      & (32'(col_s1_reg) == 32'(cur_col_s1_reg))
                      & (32'(row_s1_reg) == 32'(cur_row_s1_reg))
                      & (frow_s1_reg >= FRW'(CHAR_H - 2));

    logic [3:0]     fg_s2_reg, bg_s2_reg;
    logic [FCW-1:0] fcol_s2_reg;
    logic           hit_s2_reg, valid_s2_reg, hsync_s2_reg, vsync_s2_reg;

    // C2: glyph bit select (bit 7 is leftmost), cursor invert, palette
    logic [CHAR_W-1:0] glyph_lr;
    logic              pixel_on;
    logic [3:0]        color_idx;
    rgb12_t            color;

    for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_glyph_lr
        assign glyph_lr[gi] = font_data[CHAR_W-1-gi];
    end

    assign pixel_on  = glyph_lr[fcol_s2_reg] ^ hit_s2_reg;
    assign color_idx = pixel_on ? fg_s2_reg : bg_s2_reg;
    assign color     = PALETTE[color_idx];

    rgb12_t rgb_reg;
    logic   hsync_reg, vsync_reg;

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            fcol_s1_reg    <= '0;
            frow_s1_reg    <= '0;
            col_s1_reg     <= '0;
            row_s1_reg     <= '0;
            valid_s1_reg   <= 1'b0;
            hsync_s1_reg   <= 1'b0;
            vsync_s1_reg   <= 1'b0;
            cur_en_s1_reg  <= 1'b0;
            cur_col_s1_reg <= '0;
            cur_row_s1_reg <= '0;
            fg_s2_reg      <= '0;
            bg_s2_reg      <= '0;
            fcol_s2_reg    <= '0;
            hit_s2_reg     <= 1'b0;
            valid_s2_reg   <= 1'b0;
            hsync_s2_reg   <= 1'b0;
            vsync_s2_reg   <= 1'b0;
            rgb_reg        <= '0;
            hsync_reg      <= 1'b0;
            vsync_reg      <= 1'b0;
        end else begin
            fcol_s1_reg    <= xaddr[FCW-1:0];
            frow_s1_reg    <= yaddr[FRW-1:0];
            col_s1_reg     <= cell_col;
            row_s1_reg     <= cell_row;
            valid_s1_reg   <= addr_valid;
            hsync_s1_reg   <= hsync_in;
            vsync_s1_reg   <= vsync_in;
            cur_en_s1_reg  <= cursor_en;
            cur_col_s1_reg <= cursor_col;
            cur_row_s1_reg <= cursor_row;

            fg_s2_reg      <= attr.fg;
            bg_s2_reg      <= attr.bg;
            fcol_s2_reg    <= fcol_s1_reg;
            hit_s2_reg     <= cursor_hit;
            valid_s2_reg   <= valid_s1_reg;
            hsync_s2_reg   <= hsync_s1_reg;
            vsync_s2_reg   <= vsync_s1_reg;

            // Blanked pixels are forced black whatever the memories return.
            rgb_reg        <= valid_s2_reg ? color : '0;
            hsync_reg      <= hsync_s2_reg;
            vsync_reg      <= vsync_s2_reg;
        end
    end

    assign vga_r = rgb_reg.r;
    assign vga_g = rgb_reg.g;
    assign vga_b = rgb_reg.b;
    assign hsync = hsync_reg;
    assign vsync = vsync_reg;

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: models the synchronous text RAM and font
// ROM and checks pixels, syncs, addressing, blanking and cursor blink.
module tb_vga_text_render;

    logic        pxclk = 1'b0;
    logic        rst_n, hsync_in, vsync_in, addr_valid;
    logic [9:0]  xaddr;
    logic [8:0]  yaddr;
    logic [11:0] text_addr, font_addr;
    logic [15:0] text_data;
    logic [7:0]  font_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync;
    logic [11:0] rgb_out;

    always #5 pxclk = ~pxclk;

    vga_text_render #(
        .BLINK_FRAMES (2)
    ) dut (
        .pxclk      (pxclk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .xaddr      (xaddr),
        .yaddr      (yaddr),
        .addr_valid (addr_valid),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    assign rgb_out = {vga_r, vga_g, vga_b};

    logic [15:0] text_mem [2400];
    logic [7:0]  font_mem [4096];

    always @(posedge pxclk) begin
        text_data <= (text_addr < 12'd2400) ? text_mem[text_addr] : 16'h0000;
        font_data <= font_mem[font_addr];
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input logic v, input logic hs, input logic vs);
        xaddr      = 10'(x);
        yaddr      = 9'(y);
        addr_valid = v;
        hsync_in   = hs;
        vsync_in   = vs;
    endtask

    task automatic tick();
        @(posedge pxclk);
        #1;
    endtask

    typedef struct {
        int          x;
        int          y;
        logic        v;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int x, input int y, input logic v, input logic hs,
                       input logic vs, input logic [11:0] rgb);
        vq.push_back('{x, y, v, hs, vs, rgb});
    endtask

    // Streams queued pixels back-to-back; the output for pixel i is checked
    // after the third clock edge that follows its launch.
    task automatic run(input string name);
        int n;
        n = vq.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(vq[i].x, vq[i].y, vq[i].v, vq[i].hs, vq[i].vs);
            else       drive(0, 0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i >= 2) begin
                vec_t e;
                e = vq[i-2];
                check($sformatf("%s[%0d].rgb", name, i-2), 32'(rgb_out), 32'(e.rgb));
                check($sformatf("%s[%0d].hsync", name, i-2), 32'(hsync), 32'(e.hs));
                check($sformatf("%s[%0d].vsync", name, i-2), 32'(vsync), 32'(e.vs));
                $display("[TB] %s[%0d] x=%0d y=%0d v=%0b -> rgb=%03h hs=%0b vs=%0b",
                         name, i-2, e.x, e.y, e.v, rgb_out, hsync, vsync);
            end
        end
        vq.delete();
    endtask

    task automatic vsync_pulse();
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2400; i++) text_mem[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;
        text_mem[0]    = 16'h1F41;
        font_mem[12'h410] = 8'h80;
        text_mem[1]    = 16'hFF20;
        for (int r = 0; r < 16; r++) font_mem[12'h200 + r] = 8'hFF;
        text_mem[2399] = 16'h4E5A;
        font_mem[12'h5AF] = 8'hB2;
        text_mem[242]  = 16'h0742;
        text_mem[243]  = 16'h0742;
        text_mem[322]  = 16'h0742;
        font_mem[12'h420] = 8'hF0;
        font_mem[12'h42D] = 8'h0F;
        font_mem[12'h42E] = 8'hF0;
        font_mem[12'h42F] = 8'h0F;

        rst_n      = 1'b0;
        cursor_en  = 1'b0;
        cursor_col = 7'd0;
        cursor_row = 5'd0;
        drive(0, 0, 1'b0, 1'b0, 1'b0);

        // Reset held with toggling inputs
        for (int c = 0; c < 5; c++) begin
            drive(c * 8, c * 16, c[0], ~c[0], c[0]);
            tick();
            check($sformatf("reset[%0d].rgb", c), 32'(rgb_out), 32'h000);
            check($sformatf("reset[%0d].hsync", c), 32'(hsync), 32'h0);
            check($sformatf("reset[%0d].vsync", c), 32'(vsync), 32'h0);
            $display("[TB] reset[%0d] rgb=%03h hs=%0b vs=%0b", c, rgb_out, hsync, vsync);
        end
        check("reset.blink_on", 32'(dut.u_blink.blink_on), 32'h1);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Sync alignment and pulse width
        add(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        add(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        run("sync");

        // Single glyph and blanking
        add(0, 0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        add(1, 0, 1'b1, 1'b1, 1'b0, 12'h00A);
        add(7, 0, 1'b1, 1'b0, 1'b0, 12'h00A);
        add(8, 0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        add(8, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        add(0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
        add(0, 0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        run("glyph");

        // Address arithmetic at the last cell and an interior cell
        drive(17, 50, 1'b1, 1'b0, 1'b0);
        #1;
        check("addr.text_mid", 32'(text_addr), 32'd242);
        drive(639, 479, 1'b1, 1'b0, 1'b0);
        #1;
        check("addr.text_last", 32'(text_addr), 32'd2399);
        tick();
        check("addr.font_last", 32'(font_addr), 32'h5AF);
        $display("[TB] addr text_addr=%0d font_addr=%03h", text_addr, font_addr);
        add(632, 479, 1'b1, 1'b0, 1'b0, 12'hFF5);
        add(633, 479, 1'b1, 1'b0, 1'b0, 12'hA00);
        add(634, 479, 1'b1, 1'b0, 1'b0, 12'hFF5);
        add(635, 479, 1'b1, 1'b0, 1'b0, 12'hFF5);
        add(636, 479, 1'b1, 1'b0, 1'b0, 12'hA00);
        add(637, 479, 1'b1, 1'b0, 1'b0, 12'hA00);
        add(638, 479, 1'b1, 1'b0, 1'b0, 12'hFF5);
        add(639, 479, 1'b1, 1'b0, 1'b0, 12'hA00);
        run("lastcell");

        // Mid-frame reset flushes the pipeline; output resumes 3 cycles later
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        check("midrst.before.rgb", 32'(rgb_out), 32'hFFF);
        check("midrst.before.hsync", 32'(hsync), 32'h1);
        rst_n = 1'b0;
        tick();
        check("midrst.in.rgb", 32'(rgb_out), 32'h000);
        check("midrst.in.hsync", 32'(hsync), 32'h0);
        rst_n = 1'b1;
        tick();
        check("midrst.c1.rgb", 32'(rgb_out), 32'h000);
        tick();
        check("midrst.c2.rgb", 32'(rgb_out), 32'h000);
        tick();
        check("midrst.c3.rgb", 32'(rgb_out), 32'hFFF);
        check("midrst.c3.hsync", 32'(hsync), 32'h1);
        $display("[TB] midrst resumed rgb=%03h hs=%0b", rgb_out, hsync);

        // Cursor blink with BLINK_FRAMES=2; fresh reset puts us at frame 0
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        add(16, 62, 1'b1, 1'b0, 1'b0, 12'hAAA);
        add(20, 62, 1'b1, 1'b0, 1'b0, 12'h000);
        run("cursor_off");
        cursor_en  = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 5'd3;
        for (int f = 0; f < 4; f++) begin
            logic inv;
            if (f > 0) vsync_pulse();
            inv = (f < 2);
            add(16, 62, 1'b1, 1'b0, 1'b0, inv ? 12'h000 : 12'hAAA);
            add(20, 62, 1'b1, 1'b0, 1'b0, inv ? 12'hAAA : 12'h000);
            add(16, 63, 1'b1, 1'b0, 1'b0, inv ? 12'hAAA : 12'h000);
            add(23, 63, 1'b1, 1'b0, 1'b0, inv ? 12'h000 : 12'hAAA);
            add(16, 48, 1'b1, 1'b0, 1'b0, 12'hAAA);
            add(16, 61, 1'b1, 1'b0, 1'b0, 12'h000);
            add(24, 62, 1'b1, 1'b0, 1'b0, 12'hAAA);
            add(16, 78, 1'b1, 1'b0, 1'b0, 12'hAAA);
            run($sformatf("cursor_f%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Pixel-stream stage directly downstream of the VGA timing generator.
- Consumes hsync/vsync/xaddr/yaddr/addr_valid and fetches 8x16 character cells from an external text RAM and font ROM, both synchronous-read.
- Produces 12-bit RGB plus delayed syncs for the VGA pins, with a blinking block cursor.
- Fixed 3-cycle pipeline; syncs are delayed to match.

Parameters:
- PIXEL_WIDTH, 640, visible width; XW = $clog2(PIXEL_WIDTH).
- PIXEL_HEIGHT, 480, visible height; YW = $clog2(PIXEL_HEIGHT).
- COLS, 80, text columns = PIXEL_WIDTH/8.
- ROWS, 30, text rows = PIXEL_HEIGHT/16.
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- pxclk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- hsync_in  in  1  hsync from timing stage
- vsync_in  in  1  vsync from timing stage
- xaddr  in  XW  pixel column
- yaddr  in  YW  pixel row
- addr_valid  in  1  xaddr/yaddr in visible area
- text_addr  out  $clog2(COLS*ROWS)  text RAM address, combinational
- text_data  in  16  {attr[7:0], char[7:0]}; attr = {bg[3:0], fg[3:0]}; valid 1 cycle after address
- font_addr  out  12  font ROM address {char, frow[3:0]}, combinational
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 cycle after address
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor cell column
- cursor_row  in  5  cursor cell row
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync  out  1  hsync delayed 3 cycles
- vsync  out  1  vsync delayed 3 cycles

Behaviour:
- Reset (rst_n=0 at posedge): vga_r/g/b=0; hsync=vsync=0; all pipeline valid/sync flops=0; blink counter=0; blink_on=1.
- Cycle C0: text_addr = (yaddr>>4)*COLS + (xaddr>>3).
  - Registered into stage 1: fcol=xaddr[2:0], frow=yaddr[3:0], cell col/row, addr_valid, hsync_in, vsync_in.
- Cycle C1: text_data valid; font_addr = {text_data[7:0], frow_s1}.
  - Registered into stage 2: fg, bg, fcol, cursor hit, valid, syncs.
  - Cursor hit = cursor_en & blink_on & col==cursor_col & row==cursor_row & frow>=14.
- Cycle C2: pixel_on = font_data[7-fcol_s2] XOR cursor_hit_s2.
  - Colour = PALETTE[pixel_on ? fg : bg].
  - Registered into outputs, visible from C3.
- Latency: hsync/vsync/RGB all appear exactly 3 pxclk after the corresponding inputs.
- Blanking: if valid_s2=0, RGB registered as 0, regardless of RAM/ROM data.
- text_addr/font_addr are don't-care when the associated valid bit is 0; no gating required.
- Address arithmetic:
  - Row multiply uses constant COLS.
  - Max address COLS*ROWS-1 = 2399; no wrap within the visible area.
  - xaddr/yaddr beyond the visible range never occur while addr_valid=1.
- Blink timer:
  - Counts rising edges of vsync_in (edge detect on a registered copy).
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_on toggles.
  - Counter width $clog2(BLINK_FRAMES).
- cursor_col/row/en are sampled at C0 with the pixel; mid-frame changes take effect on the next pixel.
- Reset mid-frame: the pipeline flushes and outputs are 0 in the following cycle.
  - Normal output resumes 3 cycles after the first valid input following reset release.
- Palette (12-bit {r,g,b}), CGA order:
  - 0=000, 1=00A, 2=0A0, 3=0AA, 4=A00, 5=A0A, 6=A50, 7=AAA
  - 8=555, 9=55F, 10=5F5, 11=5FF, 12=F55, 13=F5F, 14=FF5, 15=FFF

Decomposition:
- Shared package vga_pkg:
  - CHAR_W=8, CHAR_H=16 constants.
  - rgb12_t typedef (packed struct r/g/b, 4 bits each).
  - PALETTE constant array [16] of rgb12_t.
  - attr_t packed struct {bg, fg}.
- One natural sub-module: vga_blink_timer (vsync edge detect, frame counter, blink_on output).

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with toggling inputs -> RGB=000, hsync=vsync=0 throughout; blink_on=1.
- Sync alignment: hsync_in pulse at cycle N -> hsync high at N+3, width preserved; same for vsync_in.
- Single glyph: text RAM cell 0 = {attr 0x1F, char 0x41}, font row 0 = 0x80; pixel (0,0) valid at cycle N.
  - Output at N+3 = FFF; pixel (1,0) = 00A.
- Addressing: pixel (639,479) -> text_addr=2399, font_addr={char,4'hF}; last-cell glyph bits render at xaddr 632..639 in order.
- Blanking: addr_valid=0 with font_data=0xFF, attr=0xFF -> RGB=000.
- Cursor: cursor_en=1 at (2,3), BLINK_FRAMES=2.
  - frow 14/15 of that cell inverted in frames 0-1, normal in frames 2-3.
  - Cell rows 0-13 are never inverted.
